// File: rtl/regfile_scrub.sv
//==============================================================================
// Module      : regfile_scrub
// Description : Multi-port register file with two combinational read ports and
//               one synchronous write port. Register 0 is hardwired to zero.
//               A reset launches a sequential scrub that zeroes registers
//               1..DEPTH-1, one per clock. While the scrub runs, Busy is high,
//               both read ports return zero, and any requested write is
//               discarded and reported on WriteDrop for one cycle.
//               Optional write-to-read forwarding is selected by BYPASS.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Parameters
//   WIDTH   data width of each register
//   AWIDTH  address width; DEPTH = 2**AWIDTH registers
//   BYPASS  1: a same-cycle write is forwarded to matching read ports
// Ports
//   Clk            in   1       clock; all state updates on posedge
//   Reset          in   1       synchronous, active-high reset
//   ReadRegister1  in   AWIDTH  read port 1 address
//   ReadRegister2  in   AWIDTH  read port 2 address
//   ReadData1      out  WIDTH   read port 1 data (combinational)
//   ReadData2      out  WIDTH   read port 2 data (combinational)
//   WriteRegister  in   AWIDTH  write address
//   WriteData      in   WIDTH   write data
//   RegWrite       in   1       write enable, sampled at posedge Clk
//   Busy           out  1       registered; high during reset / scrub
//   WriteDrop      out  1       registered pulse: a write was discarded
//==============================================================================
`default_nettype none

module regfile_scrub #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned AWIDTH = 5,
    parameter int unsigned BYPASS = 0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [AWIDTH-1:0] ReadRegister1,
    input  logic [AWIDTH-1:0] ReadRegister2,
    output logic [WIDTH-1:0]  ReadData1,
    output logic [WIDTH-1:0]  ReadData2,
    input  logic [AWIDTH-1:0] WriteRegister,
    input  logic [WIDTH-1:0]  WriteData,
    input  logic              RegWrite,
    output logic              Busy,
    output logic              WriteDrop
);

    localparam int unsigned       DEPTH     = 2 ** AWIDTH;
    localparam logic [AWIDTH-1:0] FIRST_IDX = {{(AWIDTH-1){1'b0}}, 1'b1};
    localparam logic [AWIDTH-1:0] LAST_IDX  = {AWIDTH{1'b1}};

    typedef enum logic [0:0] {
        ST_SCRUB = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    //--------------------------------------------------------------------------
    // State
    //--------------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [AWIDTH-1:0]   scrub_idx_q, scrub_idx_d;
    logic                busy_q, busy_d;
    logic                drop_q, drop_d;

    // Storage. Entry 0 is never written; its reads are forced to zero.
    logic [WIDTH-1:0]    mem_q [DEPTH];

    // Single internal write port shared by the scrubber and the user port.
    logic                mem_we;
    logic [AWIDTH-1:0]   mem_waddr;
    logic [WIDTH-1:0]    mem_wdata;

    // Forwarding hits per read port.
    logic                fwd1;
    logic                fwd2;

    //--------------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_SCRUB;
            scrub_idx_q <= FIRST_IDX;
            busy_q      <= 1'b1;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            scrub_idx_q <= scrub_idx_d;
            busy_q      <= busy_d;
            drop_q      <= drop_d;
        end
    end

    //--------------------------------------------------------------------------
    // FSM: next state and write-port steering
    //--------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        scrub_idx_d = scrub_idx_q;
        busy_d      = busy_q;
        drop_d      = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = WriteRegister;
        mem_wdata   = WriteData;

        unique case (state_q)
            ST_SCRUB: begin
                // The scrubber owns the write port; user writes are lost,
                // including one coinciding with the final scrub edge.
                mem_we      = 1'b1;
                mem_waddr   = scrub_idx_q;
                mem_wdata   = '0;
                scrub_idx_d = scrub_idx_q + FIRST_IDX;
                drop_d      = RegWrite;
                if (scrub_idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            ST_IDLE: begin
                // Writes to register 0 are silently ignored.
                mem_we = RegWrite && (WriteRegister != '0);
            end
            default: begin
                state_d     = ST_SCRUB;
                scrub_idx_d = FIRST_IDX;
                busy_d      = 1'b1;
            end
        endcase

        // Reset restarts the scrub without touching storage on that edge.
        if (Reset) begin
            mem_we = 1'b0;
        end
    end

    //--------------------------------------------------------------------------
    // Storage write (no reset: contents are defined by the scrub)
    //--------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    //--------------------------------------------------------------------------
    // Optional same-cycle forwarding
    //--------------------------------------------------------------------------
    if (BYPASS != 0) begin : g_bypass
        assign fwd1 = RegWrite && !busy_q && (WriteRegister != '0) &&
                      (WriteRegister == ReadRegister1);
        assign fwd2 = RegWrite && !busy_q && (WriteRegister != '0) &&
                      (WriteRegister == ReadRegister2);
    end else begin : g_no_bypass
        assign fwd1 = 1'b0;
        assign fwd2 = 1'b0;
    end

    //--------------------------------------------------------------------------
    // Read ports. Priority: busy / r0 zero > forwarded data > storage.
    // Forcing zero while busy hides stale or uninitialised contents.
    //--------------------------------------------------------------------------
    always_comb begin
        ReadData1 = mem_q[ReadRegister1];
        if (fwd1) begin
            ReadData1 = WriteData;
        end
        if (busy_q || (ReadRegister1 == '0)) begin
            ReadData1 = '0;
        end
    end

    always_comb begin
        ReadData2 = mem_q[ReadRegister2];
        if (fwd2) begin
            ReadData2 = WriteData;
        end
        if (busy_q || (ReadRegister2 == '0)) begin
            ReadData2 = '0;
        end
    end

    assign Busy      = busy_q;
    assign WriteDrop = drop_q;

endmodule

`default_nettype wire
